// File: rtl/cache_pkg.sv
// Shared widths, address-decode constants, FSM states and the cache line view.
package cache_pkg;

  localparam int unsigned IDX_W     = 6;
  localparam int unsigned TAG_W     = 10;
  localparam int unsigned WORD_SEL  = 2;
  localparam int unsigned ADDR_BASE = 1024;

  typedef enum logic [2:0] {
    IDLE,
    FILL0,
    FILL1,
    WRITE,
    WDONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      word0;
    logic [31:0]      word1;
  } line_t;

endpackage

// File: rtl/cache_array.sv
// 2-way tag/data/valid/LRU storage: combinational lookup, synchronous writes.
module cache_array
  import cache_pkg::*;
#(
  parameter int unsigned SETS  = 2 ** cache_pkg::IDX_W,
  parameter int unsigned TAG_W = cache_pkg::TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(SETS)-1:0] index,
  input  logic [TAG_W-1:0]        tag,
  input  logic                    word_sel,
  output logic                    hit,
  output logic [31:0]             hit_word,
  input  logic                    lru_touch,
  input  logic                    word_wr,
  input  logic [31:0]             word_data,
  input  logic                    fill_en,
  input  logic [31:0]             fill_word0,
  input  logic [31:0]             fill_word1
);

  logic [SETS-1:0]  valid [2];
  logic [SETS-1:0]  lru;
  logic [TAG_W-1:0] tag_mem   [2][SETS];
  logic [31:0]      word0_mem [2][SETS];
  logic [31:0]      word1_mem [2][SETS];

  line_t      ways [2];
  logic [1:0] way_hit;
  logic       hit_way;
  logic       victim;

  // Assemble the two candidate lines of the addressed set.
  always_comb begin
    ways[0] = '{valid: valid[0][index], tag: tag_mem[0][index],
                word0: word0_mem[0][index], word1: word1_mem[0][index]};
    ways[1] = '{valid: valid[1][index], tag: tag_mem[1][index],
                word0: word0_mem[1][index], word1: word1_mem[1][index]};
  end

  assign way_hit[0] = ways[0].valid && (ways[0].tag == tag);
  assign way_hit[1] = ways[1].valid && (ways[1].tag == tag);
  assign hit        = |way_hit;
  assign hit_way    = way_hit[1];
  assign hit_word   = word_sel ? ways[hit_way].word1 : ways[hit_way].word0;

  // A lone invalid way is filled first; otherwise the LRU bit picks the victim.
  assign victim = (ways[0].valid != ways[1].valid) ? ways[0].valid : lru[index];

  // Valid and LRU state; cleared asynchronously so abandoned fills never become valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
    end else begin
      if (fill_en) valid[victim][index] <= 1'b1;
      if (lru_touch && hit) lru[index] <= ~hit_way;
    end
  end

  // Tag/data storage: whole-line fills into the victim, word updates on store hits.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[victim][index]   <= tag;
      word0_mem[victim][index] <= fill_word0;
      word1_mem[victim][index] <= fill_word1;
    end else if (word_wr && hit) begin
      if (word_sel) word1_mem[hit_way][index] <= word_data;
      else          word0_mem[hit_way][index] <= word_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate 2-way data cache between MEM stage and SRAM controller.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned SETS      = 2 ** cache_pkg::IDX_W,
  parameter int unsigned TAG_W     = cache_pkg::TAG_W,
  parameter int unsigned ADDR_BASE = cache_pkg::ADDR_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] DATA,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned TAG_LSB = WORD_SEL + 1 + IDX_W;

  state_t state, next_state;

  logic [31:0]      adr;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             word_sel;
  logic             unused_adr;

  logic        hit;
  logic [31:0] hit_word;
  logic        lru_touch;
  logic        word_wr;
  logic        fill_en;
  logic        cap_en;
  logic [31:0] line_buf0;

  assign adr        = ALU_Res - ADDR_BASE;
  assign index      = adr[WORD_SEL+1 +: IDX_W];
  assign tag        = adr[TAG_LSB +: TAG_W];
  assign word_sel   = adr[WORD_SEL];
  assign unused_adr = ^{adr[WORD_SEL-1:0], adr[31:TAG_LSB+TAG_W]};

  cache_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (index),
    .tag        (tag),
    .word_sel   (word_sel),
    .hit        (hit),
    .hit_word   (hit_word),
    .lru_touch  (lru_touch),
    .word_wr    (word_wr),
    .word_data  (Val_Rm),
    .fill_en    (fill_en),
    .fill_word0 (line_buf0),
    .fill_word1 (sram_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Line buffer holding the first word of a fill until the second arrives.
  always_ff @(posedge clk) begin
    if (cap_en) line_buf0 <= sram_rdata;
  end

  // Next-state, pipeline stall and SRAM request decode.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    DATA       = '0;
    sram_r_en  = 1'b0;
    sram_w_en  = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    lru_touch  = 1'b0;
    word_wr    = 1'b0;
    fill_en    = 1'b0;
    cap_en     = 1'b0;
    case (state)
      IDLE: begin
        if (MEM_W_EN) begin
          next_state = WRITE;
        end else if (MEM_R_EN) begin
          if (hit) begin
            ready     = 1'b1;
            DATA      = hit_word;
            lru_touch = 1'b1;
          end else begin
            next_state = FILL0;
          end
        end else begin
          ready = 1'b1;
        end
      end
      FILL0: begin
        sram_r_en = 1'b1;
        sram_addr = {ALU_Res[31:3], 3'b000};
        if (sram_ready) begin
          cap_en     = 1'b1;
          next_state = FILL1;
        end
      end
      FILL1: begin
        sram_r_en = 1'b1;
        sram_addr = {ALU_Res[31:3], 3'b100};
        if (sram_ready) begin
          fill_en    = 1'b1;
          next_state = IDLE;
        end
      end
      WRITE: begin
        sram_w_en  = 1'b1;
        sram_addr  = ALU_Res;
        sram_wdata = Val_Rm;
        if (sram_ready) begin
          word_wr    = 1'b1;
          lru_touch  = 1'b1;
          next_state = WDONE;
        end
      end
      WDONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // A held load would otherwise show as a stalling miss while the arrays are cleared.
    if (!rst) ready = 1'b1;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
- Accepts MEM-stage load/store requests and answers load hits with zero added cycles.
- Misses and all stores are forwarded to the SRAM controller as word-sized read/write transactions.
- Drives ready low to freeze the pipeline while an SRAM transaction is outstanding.

Parameters:
- SETS, 64: number of sets; index width = log2(SETS).
- TAG_W, 10: tag width. Address bits [18:9] with the defaults.
- ADDR_BASE, 1024: data-memory base subtracted from ALU_Res before decoding.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous and active-low.
- MEM_R_EN  input  1  load request from the MEM stage.
- MEM_W_EN  input  1  store request from the MEM stage.
- ALU_Res  input  32  byte address, pre-offset.
- Val_Rm  input  32  store data.
- DATA  output  32  load result; valid when MEM_R_EN && ready.
- ready  output  1  0 = freeze the other stages.
- sram_r_en  output  1  word read request to the SRAM controller.
- sram_w_en  output  1  word write request to the SRAM controller.
- sram_addr  output  32  pre-offset byte address passed to the SRAM controller.
- sram_wdata  output  32  write data.
- sram_rdata  input  32  read data; valid when sram_ready is high.
- sram_ready  input  1  SRAM controller completion; high for one cycle when the access finishes.

Behaviour:
- Address decode: adr = ALU_Res - ADDR_BASE.
  - adr[1:0] ignored (word-aligned).
  - adr[2] selects the word in a 2-word line.
  - adr[8:3] = index; adr[18:9] = tag.
- Storage per set: 2 ways, each holding {valid, tag, word0, word1}, plus one LRU bit (the bit names the way to replace next).
- Reset (rst low, async):
  - All valid bits = 0, all LRU bits = 0, state = IDLE.
  - Outputs: ready=1, DATA=0, sram_r_en=0, sram_w_en=0, sram_addr=0, sram_wdata=0.
  - Data/tag arrays need no reset.
- Both MEM_R_EN and MEM_W_EN high: treated as a store. The load is ignored.
- IDLE:
  - No request: ready=1.
  - Load hit (valid && tag match in either way): DATA = selected word combinationally, ready=1. LRU[index] <= other way. No SRAM traffic.
  - Load miss: ready=0, go FILL0.
  - Store: ready=0, go WRITE.
- FILL0:
  - sram_r_en=1, sram_addr = {ALU_Res[31:3],3'b000}, ready=0.
  - On sram_ready: capture sram_rdata into a line buffer word0, go FILL1.
- FILL1:
  - sram_r_en=1, sram_addr = {ALU_Res[31:3],3'b100}, ready=0.
  - On sram_ready: write {valid=1, tag, buf word0, sram_rdata} into way LRU[index], go IDLE.
  - The held request then hits in IDLE. Read-miss latency = 2 SRAM accesses + 1 cycle.
- WRITE:
  - sram_w_en=1, sram_addr=ALU_Res, sram_wdata=Val_Rm, ready=0.
  - On sram_ready: if hit, update the addressed word in the hit way and set LRU to the other way. On a miss, no allocate and no LRU change. Go WDONE.
- WDONE: ready=1 for exactly one cycle, no SRAM request, then IDLE. This prevents re-issuing the held store.
- Request hold rule: the upstream holds MEM_R_EN, MEM_W_EN, ALU_Res and Val_Rm stable while ready=0. Changes in that window are undefined.
- sram_r_en / sram_w_en stay asserted and stable until sram_ready is sampled high. They are never both high.
- sram_ready arriving in IDLE or WDONE is ignored.
- Reset mid-FILL or mid-WRITE: transaction abandoned, all lines invalid. A partially filled line never becomes valid.
- Invalid way preferred on allocation: if exactly one way is invalid, fill it regardless of LRU.

Decomposition:
- cache_pkg holds:
  - Field-width constants: IDX_W, TAG_W, the WORD_SEL bit position.
  - ADDR_BASE.
  - State enum {IDLE, FILL0, FILL1, WRITE, WDONE}.
  - Line struct {valid, tag, word0, word1}.
- One natural sub-module: cache_array. It holds the 2-way tag/data/valid/LRU storage, with combinational hit/way/data lookup and synchronous write ports. cache_controller holds the FSM and the SRAM handshake.

Test Plan:
- Reset then load 0x400 (adr 0) with SRAM word0=0x11111111, word1=0x22222222:
  - ready low through two sram_r_en transactions at addr 0x400 and 0x404.
  - DATA=0x11111111 with ready=1 afterwards.
  - A following load of 0x404 hits: DATA=0x22222222, zero stall, no sram_r_en.
- Store 0x404 <- 0xDEADBEEF after that fill:
  - exactly one sram_w_en at 0x404.
  - ready=1 for one cycle in WDONE.
  - Subsequent load of 0x404 hits with 0xDEADBEEF.
- Store to uncached 0x800: one SRAM write. A following load of 0x800 misses (no allocate) and issues two reads.
- Loads to 0x400, 0x4400, 0x400 (hit), then 0x8400 (same index, third tag):
  - 0x8400 evicts the 0x4400 line (LRU).
  - Reloading 0x400 hits; reloading 0x4400 misses.
- MEM_R_EN and MEM_W_EN both high at 0x408: treated as a store (sram_w_en only, no fill).
- Assert rst low while in FILL1 before sram_ready:
  - Immediately: ready=1 and sram_r_en=0.
  - After release, a load of the same address misses again.
